// File: rtl/reg_status_file_pkg.sv
// Shared configuration for the register status file: RoB tag sizing,
// architectural register count and index width, plus the operand source
// encoding used by the read ports.
package reg_status_file_pkg;

    localparam int ROB_SIZE_WIDTH = 4;
    localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH;
    localparam int REG_NUM        = 32;
    localparam int REG_IDX_W      = 5;

    // Where a resolved source operand comes from, in priority order.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_REG,
        SRC_COMMIT,
        SRC_ROB,
        SRC_PEND
    } operand_src_e;

endpackage

// File: rtl/reg_read_port.sv
// Single source-operand resolver: picks between x0, the committed value,
// the commit broadcast, the RoB forwarded value, or reports the operand
// as pending on its producing tag.
// Optional feature macro: REG_COMMIT_BYPASS_EN (forward the same-cycle
// commit value for a matching busy register).
module reg_read_port #(
    parameter int ROB_SIZE_WIDTH = reg_status_file_pkg::ROB_SIZE_WIDTH
) (
    input  logic [reg_status_file_pkg::REG_IDX_W-1:0] idx,
    input  logic                                      busy,
    input  logic [ROB_SIZE_WIDTH-1:0]                 tag,
    input  logic [31:0]                               reg_val,
    input  logic                                      commit_valid,
    input  logic [reg_status_file_pkg::REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_SIZE_WIDTH-1:0]                 commit_rob_id,
    input  logic [31:0]                               commit_value,
    input  logic                                      get_ready,
    input  logic [31:0]                               get_value,
    output logic [31:0]                               val,
    output logic                                      dep,
    output logic [ROB_SIZE_WIDTH-1:0]                 pend_tag,
    output logic [ROB_SIZE_WIDTH-1:0]                 query_tag
);

    import reg_status_file_pkg::*;

    operand_src_e src;
    logic         commit_hit;

`ifndef REG_COMMIT_BYPASS_EN
    // Commit value is only forwarded when the bypass is built in.
    logic unused_commit_value;
    assign unused_commit_value = ^commit_value;
`endif

    // Retiring instruction is exactly the current owner of this register.
    assign commit_hit = commit_valid && (commit_rd == idx) && (commit_rob_id == tag);

    // Select the operand source in priority order.
    always_comb begin
        src = SRC_PEND;
        if (idx == '0) begin
            src = SRC_ZERO;
        end else if (!busy) begin
            src = SRC_REG;
`ifdef REG_COMMIT_BYPASS_EN
        end else if (commit_hit) begin
            src = SRC_COMMIT;
`endif
        end else if (get_ready) begin
            src = SRC_ROB;
        end
    end

    // Drive value, pending flag and tags from the chosen source.
    always_comb begin
        val       = '0;
        dep       = 1'b0;
        pend_tag  = '0;
        query_tag = (src == SRC_ZERO || !busy) ? '0 : tag;
        unique case (src)
            SRC_ZERO:   val = '0;
            SRC_REG:    val = reg_val;
`ifdef REG_COMMIT_BYPASS_EN
            SRC_COMMIT: val = commit_value;
`else
            SRC_COMMIT: val = '0;
`endif
            SRC_ROB:    val = get_value;
            SRC_PEND: begin
                dep      = 1'b1;
                pend_tag = commit_hit ? commit_rob_id : tag;
            end
            default:    val = '0;
        endcase
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy bit
// and owning RoB tag). Records renames at issue, retires values at commit,
// flushes rename state on clear, and resolves two source operands.
// Optional feature macro: REG_COMMIT_BYPASS_EN (see reg_read_port).
module reg_status_file #(
    parameter int ROB_SIZE_WIDTH = reg_status_file_pkg::ROB_SIZE_WIDTH,
    parameter int REG_NUM        = reg_status_file_pkg::REG_NUM
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      rdy,
    input  logic                                      clear,
    input  logic                                      issue_valid,
    input  logic [reg_status_file_pkg::REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_SIZE_WIDTH-1:0]                 issue_rob_id,
    input  logic                                      commit_valid,
    input  logic [reg_status_file_pkg::REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_SIZE_WIDTH-1:0]                 commit_rob_id,
    input  logic [31:0]                               commit_value,
    input  logic [reg_status_file_pkg::REG_IDX_W-1:0] rs1,
    input  logic [reg_status_file_pkg::REG_IDX_W-1:0] rs2,
    output logic [31:0]                               val1,
    output logic [31:0]                               val2,
    output logic                                      dep1,
    output logic                                      dep2,
    output logic [ROB_SIZE_WIDTH-1:0]                 tag1,
    output logic [ROB_SIZE_WIDTH-1:0]                 tag2,
    output logic [ROB_SIZE_WIDTH-1:0]                 get_rob_id1,
    output logic [ROB_SIZE_WIDTH-1:0]                 get_rob_id2,
    input  logic                                      get_ready1,
    input  logic                                      get_ready2,
    input  logic [31:0]                               get_value1,
    input  logic [31:0]                               get_value2
);

    import reg_status_file_pkg::*;

    logic [31:0]               regs [REG_NUM];
    logic                      busy [REG_NUM];
    logic [ROB_SIZE_WIDTH-1:0] tag  [REG_NUM];

    logic commit_we;
    logic issue_we;

    assign commit_we = rdy && commit_valid && (commit_rd != '0);
    assign issue_we  = rdy && issue_valid && (issue_rd != '0) && !clear;

    // Commit retires values, issue renames, clear drops all renames.
    // Later assignments win: issue overrides a same-cycle commit busy-clear,
    // and clear overrides both while the commit value still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
                busy[i] <= 1'b0;
                tag[i]  <= '0;
            end
        end else if (rdy) begin
            if (commit_we) begin
                regs[commit_rd] <= commit_value;
                if (tag[commit_rd] == commit_rob_id) begin
                    busy[commit_rd] <= 1'b0;
                end
            end
            if (clear) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    busy[i] <= 1'b0;
                    tag[i]  <= '0;
                end
            end else if (issue_we) begin
                busy[issue_rd] <= 1'b1;
                tag[issue_rd]  <= issue_rob_id;
            end
        end
    end

    reg_read_port #(
        .ROB_SIZE_WIDTH (ROB_SIZE_WIDTH)
    ) u_port1 (
        .idx           (rs1),
        .busy          (busy[rs1]),
        .tag           (tag[rs1]),
        .reg_val       (regs[rs1]),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .get_ready     (get_ready1),
        .get_value     (get_value1),
        .val           (val1),
        .dep           (dep1),
        .pend_tag      (tag1),
        .query_tag     (get_rob_id1)
    );

    reg_read_port #(
        .ROB_SIZE_WIDTH (ROB_SIZE_WIDTH)
    ) u_port2 (
        .idx           (rs2),
        .busy          (busy[rs2]),
        .tag           (tag[rs2]),
        .reg_val       (regs[rs2]),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .get_ready     (get_ready2),
        .get_value     (get_value2),
        .val           (val2),
        .dep           (dep2),
        .pend_tag      (tag2),
        .query_tag     (get_rob_id2)
    );

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file with per-register rename status for the out-of-order core. Sits between the decoder/issue stage and the reorder buffer. It holds 32 committed values plus a busy bit and owning RoB tag per register. It records renames at issue, retires values at commit, and resolves source operands for newly issued instructions, querying the RoB for in-flight results.

## Interface
Parameters:
- ROB_SIZE_WIDTH, default `ROB_SIZE_WIDTH (4): RoB tag width.
- REG_NUM, default 32: number of architectural registers.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; when low, no state changes.
- clear  in  1  mispredict flush.
- issue_valid  in  1  an instruction is being renamed this cycle.
- issue_rd  in  5  destination register; 0 means no rename.
- issue_rob_id  in  ROB_SIZE_WIDTH  RoB tag allocated to the issuing instruction.
- commit_valid  in  1  the RoB head retires with a register write.
- commit_rd  in  5  retiring destination register.
- commit_rob_id  in  ROB_SIZE_WIDTH  retiring tag.
- commit_value  in  32  retiring value.
- rs1, rs2  in  5 each  source register indices of the issuing instruction.
- val1, val2  out  32 each  operand value, valid when the matching dep bit is 0.
- dep1, dep2  out  1 each  operand still pending.
- tag1, tag2  out  ROB_SIZE_WIDTH each  producing RoB tag when pending, else 0.
- get_rob_id1, get_rob_id2  out  ROB_SIZE_WIDTH each  RoB query tag (tag of rs1/rs2 when busy, else 0).
- get_ready1, get_ready2  in  1 each  RoB reports the queried entry as ready.
- get_value1, get_value2  in  32 each  RoB value for the queried entry.

## Operation
- State: regs[0..31] (32 bits), busy[0..31], tag[0..31].
- x0: reads always return val=0, dep=0, tag=0. Writes, renames and busy changes to index 0 are ignored.
- Read resolution, combinational, per port, in priority order:
  - index 0 → (0, dep=0).
  - !busy → (regs, dep=0).
  - Commit bypass hit (see Configuration) → (commit_value, dep=0).
  - get_ready → (get_value, dep=0).
  - otherwise → dep=1, tag=tag[rs].
- Reads observe state before this cycle's issue, so `addi x5,x5,1` reads the old producer of x5, not its own tag.
- Commit (rdy && commit_valid && commit_rd≠0):
  - regs[rd] ← commit_value.
  - busy[rd] ← 0 only if tag[rd]==commit_rob_id; otherwise busy and tag are unchanged, because a younger rename owns the register.
- Issue (rdy && issue_valid && issue_rd≠0 && !clear): busy[rd] ← 1, tag[rd] ← issue_rob_id.
- Same-cycle issue and commit to the same rd: the commit value is written and the issue rename wins (busy=1, new tag).
- Flush (rdy && clear):
  - All busy ← 0 and all tags ← 0.
  - A same-cycle commit still writes regs.
  - A same-cycle issue is dropped.
- rdy low: state holds; combinational outputs still reflect current state and inputs.

## Timing
- Reset: regs, busy and tag are all 0, so every output is 0.
- Read path has zero latency (pure combinational from state plus RoB/commit inputs).
- Issue, commit and flush updates become visible on the next rising edge.
- No handshakes. The RoB guarantees at most one commit and one issue per cycle and never issues a tag that is still live.
- A reset asserted mid-operation clears all state immediately, independent of clk and rdy.

## Configuration
- REG_COMMIT_BYPASS_EN, when defined:
  - A read of rs with busy[rs], commit_valid, commit_rd==rs and commit_rob_id==tag[rs] returns commit_value with dep=0 in the same cycle.
- When not defined:
  - That read returns dep=1 and tag=commit_rob_id.
  - The consumer must capture the value from the commit broadcast.

## Structure
- The shared config include holds: ROB_SIZE_WIDTH, ROB_SIZE, REG_NUM, and the 5-bit register index width.
- One sub-module, reg_read_port, instantiated twice. It performs the priority resolution for a single operand from (index, busy, tag, regs value, commit inputs, get_ready/get_value).

## Test plan
- Reset then read rs1=7, rs2=0 → val1=0, dep1=0, val2=0, dep2=0.
- Issue rd=5 tag=3; next cycle read rs1=5 with get_ready1=0 → dep1=1, tag1=3, get_rob_id1=3. Then get_ready1=1, get_value1=0x55 → val1=0x55, dep1=0.
- Issue rd=5 tag=3, then issue rd=5 tag=6, then commit rd=5 tag=3 value=0x11 → regs[5]=0x11, busy stays 1, tag=6. Commit tag=6 value=0x22 → busy=0, read returns 0x22.
- Same-cycle issue rd=9 tag=2 and commit rd=9 tag=1 value=0xA → next cycle regs[9]=0xA, busy=1, tag=2.
- Registers 3 and 4 busy, clear with a same-cycle commit rd=3 value=0x7 → all busy=0, rs1=3 reads 0x7, issue in that cycle ignored.
- Bypass: with REG_COMMIT_BYPASS_EN defined, x8 busy with tag 4, commit rd=8 tag=4 value=0x99 while reading rs1=8 → val1=0x99, dep1=0. Without the macro → dep1=1, tag1=4.
